// File: rtl/fsm_processador_tx.sv
// rtl/fsm_processador_tx.sv - FIFO-buffered 4-phase dado/send/ack sender feeding fsmPeriferico1
// Optional abort-on-stall controlled by macro FSM_TX_TIMEOUT_EN.
module fsm_processador_tx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic        ovf,
    output logic [15:0] dado,
    output logic [1:0]  send,
    input  logic [1:0]  ack,
    output logic        busy,
    output logic [15:0] sent_cnt,
    output logic        tmo
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_REL  = 2'b10
    } state_t;

    state_t      r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_dado;
    logic [1:0]  r_send;
    logic        r_ovf;
    logic [15:0] r_sent_cnt;
    logic        w_pop;
    logic        w_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = (r_state == S_IDLE) && !empty;
    assign w_push = wr_en && (!full || w_pop);

    assign dado     = r_dado;
    assign send     = r_send;
    assign ovf      = r_ovf;
    assign sent_cnt = r_sent_cnt;
    assign busy     = (r_state != S_IDLE);

`ifdef FSM_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] r_wait;
    logic          r_tmo;
    assign tmo = r_tmo;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dado     <= '0;
            r_send     <= 2'b00;
            r_ovf      <= 1'b0;
            r_sent_cnt <= '0;
`ifdef FSM_TX_TIMEOUT_EN
            r_wait     <= '0;
            r_tmo      <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (wr_en && !w_push) begin
                r_ovf <= 1'b1;
            end
`ifdef FSM_TX_TIMEOUT_EN
            r_tmo <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!empty) begin
                        r_dado   <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_send   <= 2'b01;
                        r_state  <= S_REQ;
`ifdef FSM_TX_TIMEOUT_EN
                        r_wait   <= '0;
`endif
                    end else begin
                        r_send <= 2'b00;
                    end
                end
                S_REQ: begin
                    if (ack == 2'b01) begin
                        r_send  <= 2'b00;
                        r_state <= S_REL;
`ifdef FSM_TX_TIMEOUT_EN
                        r_wait  <= '0;
                    end else if (r_wait == TW'(TIMEOUT - 1)) begin
                        r_send  <= 2'b00;
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
`endif
                    end
                end
                S_REL: begin
                    if (ack == 2'b00) begin
                        r_sent_cnt <= r_sent_cnt + 1'b1;
                        r_state    <= S_IDLE;
`ifdef FSM_TX_TIMEOUT_EN
                    end else if (r_wait == TW'(TIMEOUT - 1)) begin
                        r_send  <= 2'b00;
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
`endif
                    end
                end
                default: begin
                    r_send  <= 2'b00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
